// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of the 8-bit basic ALU.
// Commands are queued in a small FIFO and issued one at a time as registered ALU operands.
// The ALU outputs are captured one cycle later and offered on a result port.
// A chained command takes the last captured result as operand A, which gives accumulator behaviour.
//
// Handshake rule for both ports:
// - A transfer happens on a rising edge where valid and ready are both high.
// - cmd_ready does not depend on cmd_valid.
// - res_valid and res_* stay stable until the edge where res_ready is seen high.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [7:0]    cmd_a,
  input  logic [7:0]    cmd_b,
  input  logic [2:0]    cmd_sel,
  input  logic          cmd_chain,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic [2:0]    alu_sel,
  input  logic [7:0]    alu_result,
  input  logic          alu_zero,
  input  logic          alu_carry,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [7:0]    res_data,
  output logic          res_zero,
  output logic          res_carry,
  output logic          res_illegal,
  output logic [LW-1:0] fifo_level,
  output logic [1:0]    dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic          full, empty, push, pop;
  logic [EW-1:0] head;
  logic [7:0]    acc_q;

  assign full       = (count == LW'(DEPTH));
  assign empty      = (count == '0);
  assign cmd_ready  = !full;
  // A pop in the same cycle never frees room for a push; push looks only at full.
  assign push       = cmd_valid && !full;
  assign fifo_level = count;
  assign head       = mem[rd_ptr];
  assign dbg_state  = state_q;

  // Command storage.
  // The pointers are a power-of-two width, so they wrap on their own.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_chain, cmd_sel, cmd_b, cmd_a};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and pop decision.
  // A pop always loads the ALU operands in the same cycle.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: state_d = DONE;
      DONE: begin
        if (res_ready) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand load on pop, and result capture in EXEC.
  // The accumulator mirrors the held result, so a chain popped in DONE sees that result.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= '0;
      acc_q       <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_zero    <= 1'b0;
      res_carry   <= 1'b0;
      res_illegal <= 1'b0;
    end else begin
      if (pop) begin
        alu_a   <= head[19] ? acc_q : head[7:0];
        alu_b   <= head[15:8];
        alu_sel <= head[18:16];
      end
      if (state_q == EXEC) begin
        res_data    <= alu_result;
        res_zero    <= alu_zero;
        res_carry   <= alu_carry;
        res_illegal <= (alu_sel > 3'd4);
        acc_q       <= alu_result;
        res_valid   <= 1'b1;
      end else if (state_q == DONE && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer.
// A behavioural 8-bit ALU closes the loop between alu_* and alu_result/zero/carry.
module tb_alu_cmd_sequencer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a, cmd_b;
  logic [2:0] cmd_sel;
  logic       cmd_chain;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_result;
  logic       alu_zero, alu_carry;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic       res_zero, res_carry, res_illegal;
  logic [2:0] fifo_level;
  logic [1:0] dbg_state;

  int checks = 0;
  int passed = 0;
  logic [7:0] exp_q[$];

  alu_cmd_sequencer #(.DEPTH(4), .LW(3)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_chain(cmd_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_zero(res_zero), .res_carry(res_carry),
    .res_illegal(res_illegal), .fifo_level(fifo_level), .dbg_state(dbg_state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU.
  // SUB carry means "no borrow".
  // Opcodes 5..7 return 0 with carry 0.
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum = 9'd0;
    case (alu_sel)
      3'd0: alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
      3'd2: alu_sum = {1'b0, alu_a & alu_b};
      3'd3: alu_sum = {1'b0, alu_a | alu_b};
      3'd4: alu_sum = {1'b0, ~alu_b};
      default: alu_sum = 9'd0;
    endcase
  end
  assign alu_result = alu_sum[7:0];
  assign alu_carry  = alu_sum[8];
  assign alu_zero   = (alu_sum[7:0] == 8'h00);

  // Driver tasks.
  // Single-cycle push; only called while the FIFO has room.
  task automatic send_cmd(input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] sel, input logic chain);
    cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_chain = chain;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for a result, snapshot it, then accept it with a one-cycle res_ready pulse.
  task automatic get_result(output logic [7:0] d, output logic z, output logic c,
                            output logic il, output logic got);
    got = 1'b0; d = '0; z = 1'b0; c = 1'b0; il = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (res_valid) begin
        got = 1'b1; d = res_data; z = res_zero; c = res_carry; il = res_illegal;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (got) begin
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b want 0", res_valid); else passed++;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); else passed++;
    checks++; if (fifo_level !== 3'd0) $display("FAIL reset_fifo_level: got %0d want 0", fifo_level); else passed++;
    checks++; if ({alu_a, alu_b, alu_sel} !== 19'd0) $display("FAIL reset_alu_ops: got %h want 0", {alu_a, alu_b, alu_sel}); else passed++;
    checks++; if ({res_data, res_zero, res_carry, res_illegal} !== 11'd0) $display("FAIL reset_res: got %h want 0", {res_data, res_zero, res_carry, res_illegal}); else passed++;
    checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_add_latency();
    logic [7:0] d; logic z, c, il, got;
    send_cmd(8'hF0, 8'h20, 3'd0, 1'b0);
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b0) $display("FAIL add_latency_early: got %b want 0", res_valid); else passed++;
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b1) $display("FAIL add_latency: got %b want 1", res_valid); else passed++;
    get_result(d, z, c, il, got);
    checks++; if (got !== 1'b1) $display("FAIL add_timeout: got %b want 1", got); else passed++;
    checks++; if ({d, z, c, il} !== {8'h10, 1'b0, 1'b1, 1'b0}) $display("FAIL add_result: got %h/%b%b%b want 10/010", d, z, c, il); else passed++;
    checks++; if (res_valid !== 1'b0) $display("FAIL add_res_drop: got %b want 0", res_valid); else passed++;
  endtask

  task automatic test_sub();
    logic [7:0] d; logic z, c, il, got;
    send_cmd(8'h05, 8'h05, 3'd1, 1'b0);
    get_result(d, z, c, il, got);
    checks++; if ({got, d, z, c} !== {1'b1, 8'h00, 1'b1, 1'b1}) $display("FAIL sub_equal: got %b %h z%b c%b want 1 00 z1 c1", got, d, z, c); else passed++;
    send_cmd(8'h03, 8'h05, 3'd1, 1'b0);
    get_result(d, z, c, il, got);
    checks++; if ({got, d, z, c} !== {1'b1, 8'hFE, 1'b0, 1'b0}) $display("FAIL sub_borrow: got %b %h z%b c%b want 1 FE z0 c0", got, d, z, c); else passed++;
  endtask

  task automatic test_chain();
    logic [7:0] d; logic z, c, il, got;
    send_cmd(8'h01, 8'h01, 3'd0, 1'b0);
    get_result(d, z, c, il, got);
    checks++; if ({got, d} !== {1'b1, 8'h02}) $display("FAIL chain_seed: got %b %h want 1 02", got, d); else passed++;
    send_cmd(8'hAA, 8'h03, 3'd0, 1'b1);
    get_result(d, z, c, il, got);
    checks++; if ({got, d} !== {1'b1, 8'h05}) $display("FAIL chain_add: got %b %h want 1 05", got, d); else passed++;
    send_cmd(8'h00, 8'hF0, 3'd3, 1'b1);
    @(posedge clk); #1;
    checks++; if (alu_a !== 8'h05) $display("FAIL chain_alu_a: got %h want 05", alu_a); else passed++;
    get_result(d, z, c, il, got);
    checks++; if ({got, d} !== {1'b1, 8'hF5}) $display("FAIL chain_or: got %b %h want 1 F5", got, d); else passed++;
  endtask

  task automatic test_back_to_back();
    int acc_cnt;
    int last;
    acc_cnt = 0;
    res_ready = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      cmd_a = 8'(i * 16 + 1); cmd_b = 8'h02; cmd_sel = 3'd0; cmd_chain = 1'b0;
      cmd_valid = 1'b1;
      if (cmd_ready) begin
        exp_q.push_back(8'(i * 16 + 3));
        acc_cnt++;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    checks++; if (acc_cnt !== 5) $display("FAIL cap_accepted: got %0d want 5", acc_cnt); else passed++;
    checks++; if (cmd_ready !== 1'b0) $display("FAIL cap_cmd_ready: got %b want 0", cmd_ready); else passed++;
    checks++; if (fifo_level !== 3'd4) $display("FAIL cap_fifo_level: got %0d want 4", fifo_level); else passed++;
    checks++; if ({res_valid, res_data} !== {1'b1, 8'h03}) $display("FAIL cap_first_held: got %b %h want 1 03", res_valid, res_data); else passed++;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({res_valid, res_data} !== {1'b1, 8'h03}) $display("FAIL cap_stable: got %b %h want 1 03", res_valid, res_data); else passed++;
    res_ready = 1'b1;
    last = -1;
    for (int cyc = 0; cyc < 30 && exp_q.size() > 0; cyc++) begin
      if (res_valid) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        checks++; if (res_data !== e) $display("FAIL cap_order: got %h want %h", res_data, e); else passed++;
        if (last >= 0) begin
          checks++; if (cyc - last !== 2) $display("FAIL cap_spacing: got %0d want 2", cyc - last); else passed++;
        end
        last = cyc;
      end
      @(posedge clk); #1;
    end
    res_ready = 1'b0;
    checks++; if (exp_q.size() !== 0) $display("FAIL cap_drain: got %0d left want 0", exp_q.size()); else passed++;
  endtask

  task automatic test_illegal();
    logic [7:0] d; logic z, c, il, got;
    send_cmd(8'h12, 8'h34, 3'd6, 1'b0);
    get_result(d, z, c, il, got);
    checks++; if ({got, d, z, c, il} !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b1}) $display("FAIL illegal: got %b %h z%b c%b il%b want 1 00 z1 c0 il1", got, d, z, c, il); else passed++;
  endtask

  task automatic test_reset_in_done();
    logic [7:0] d; logic z, c, il, got;
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_a = 8'(i + 1); cmd_b = 8'(i + 1); cmd_sel = 3'd0; cmd_chain = 1'b0;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    checks++; if ({res_valid, fifo_level} !== {1'b1, 3'd3}) $display("FAIL rst_done_setup: got %b %0d want 1 3", res_valid, fifo_level); else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({res_valid, fifo_level, cmd_ready} !== {1'b0, 3'd0, 1'b1}) $display("FAIL rst_done_clear: got %b %0d %b want 0 0 1", res_valid, fifo_level, cmd_ready); else passed++;
    send_cmd(8'h55, 8'h07, 3'd0, 1'b1);
    get_result(d, z, c, il, got);
    checks++; if ({got, d} !== {1'b1, 8'h07}) $display("FAIL rst_chain_acc: got %b %h want 1 07", got, d); else passed++;
    checks++; if (alu_a !== 8'h00) $display("FAIL rst_chain_alu_a: got %h want 00", alu_a); else passed++;
  endtask

  // Test sequence and final report.
  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0;
    cmd_chain = 1'b0; res_ready = 1'b0;
    test_reset();
    test_add_latency();
    test_sub();
    test_chain();
    test_back_to_back();
    test_illegal();
    test_reset_in_done();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
